// File: rtl/brick_frame_responder_pkg.sv
// Shared definitions for the brick frame responder.
// Holds the bitmap geometry, coordinate width, the FSM state encoding and
// the alive/dead encoding of one bitmap entry.
package brick_frame_responder_pkg;

   localparam int NB_BRIQUES      = 400;
   localparam int ADR_W           = 9;
   localparam int POS_W           = 11;
   localparam int DEF_TIMEOUT_CYC = 1000000;

   // One bitmap bit per brick.
   localparam logic BRICK_ALIVE = 1'b1;
   localparam logic BRICK_DEAD  = 1'b0;

   // Typed copies of the brick count for address compares and the alive counter.
   localparam logic [ADR_W-1:0] NB_ADR   = ADR_W'(NB_BRIQUES);
   localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(NB_BRIQUES - 1);
   localparam logic [ADR_W-1:0] ADR_ONE  = ADR_W'(1);
   localparam logic [ADR_W:0]   NB_CNT   = (ADR_W + 1)'(NB_BRIQUES);
   localparam logic [ADR_W:0]   CNT_ONE  = (ADR_W + 1)'(1);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_CALC = 2'd2
   } state_t;

endpackage

// File: rtl/brick_status_ram.sv
// Alive bitmap for the bricks.
// One write port (init fill or kill) feeding two identical copies written in
// lockstep, so each copy is a plain one-write/one-read RAM. Copy A serves the
// Nios query port, copy B the VGA renderer. Both reads are registered and see
// the pre-write contents when read and write hit the same address.
// Addresses at or above NB_BRIQUES read as dead.
//   clk, reset_n          : clock, async active-low reset (read registers only)
//   wr_en/wr_adr/wr_alive : write port
//   rd_adr_a / rd_alive_a : Nios read port, 1-cycle latency
//   rd_adr_b / rd_alive_b : VGA read port, 1-cycle latency
module brick_status_ram
   import brick_frame_responder_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [ADR_W-1:0] wr_adr,
   input  logic             wr_alive,
   input  logic [ADR_W-1:0] rd_adr_a,
   output logic             rd_alive_a,
   input  logic [ADR_W-1:0] rd_adr_b,
   output logic             rd_alive_b
);

   logic mem_a [NB_BRIQUES];
   logic mem_b [NB_BRIQUES];

   // Contents are not reset; the INIT sweep in the top rewrites every entry.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_adr < NB_ADR)) begin
         mem_a[wr_adr] <= wr_alive;
         mem_b[wr_adr] <= wr_alive;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_alive_a <= BRICK_DEAD;
         rd_alive_b <= BRICK_DEAD;
      end else begin
         rd_alive_a <= (rd_adr_a < NB_ADR) ? mem_a[rd_adr_a] : BRICK_DEAD;
         rd_alive_b <= (rd_adr_b < NB_ADR) ? mem_b[rd_adr_b] : BRICK_DEAD;
      end
   end

endmodule

// File: rtl/brick_frame_responder.sv
// Hardware responder for the Nios ball-calculation core.
// Owns the brick bitmap, answers brick queries, applies kills, runs the
// per-frame en -> fincalcul handshake with a timeout, latches ball position
// and freezes the paddle position for each calculation.
//   clk, reset_n                   : clock, async active-low reset
//   frame_start, raquette_in       : VGA frame pulse, live paddle
//   en, fincalcul                  : calculation request / done
//   x_position, y_position, perdu  : ball result and ball-lost flag
//   adr_brique, en_nios            : Nios brick query / kill strobe
//   brique_morte                   : query result, 1 = dead or absent
//   pos_raquette, ball_x, ball_y   : frame-stable paddle, last ball
//   vga_adr, vga_alive             : renderer query, 1 = alive
//   nb_restantes, all_cleared      : alive count, level cleared
//   timeout_err                    : sticky handshake timeout
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_INIT | sweep alive=1 into every brick, one address per cycle
// ST_IDLE | wait for frame_start; restart at INIT if ball was lost
// ST_CALC | en issued, waiting for fincalcul or the timeout
module brick_frame_responder
   import brick_frame_responder_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             frame_start,
   input  logic [POS_W-1:0] raquette_in,
   output logic             en,
   input  logic             fincalcul,
   input  logic [POS_W-1:0] x_position,
   input  logic [POS_W-1:0] y_position,
   input  logic             perdu,
   input  logic [ADR_W-1:0] adr_brique,
   input  logic             en_nios,
   output logic             brique_morte,
   output logic [POS_W-1:0] pos_raquette,
   output logic [POS_W-1:0] ball_x,
   output logic [POS_W-1:0] ball_y,
   input  logic [ADR_W-1:0] vga_adr,
   output logic             vga_alive,
   output logic [ADR_W:0]   nb_restantes,
   output logic             all_cleared,
   output logic             timeout_err
);

   localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
   // Down-counter loaded so that CALC lasts exactly TIMEOUT_CYC cycles.
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

   state_t           state;
   logic [ADR_W-1:0] init_ptr;
   logic [TMO_W-1:0] tmo_cnt;
   logic             perdu_q;
   logic             kill_q;

   logic             in_init;
   logic             kill_ok;
   logic             wr_en;
   logic [ADR_W-1:0] wr_adr;
   logic             wr_alive;
   logic             rd_alive_a;
   logic             rd_alive_b;

   assign in_init  = (state == ST_INIT);
   assign kill_ok  = en_nios && !in_init && (adr_brique < NB_ADR);
   assign wr_en    = in_init || kill_ok;
   assign wr_adr   = in_init ? init_ptr : adr_brique;
   assign wr_alive = in_init ? BRICK_ALIVE : BRICK_DEAD;

   brick_status_ram u_ram (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .wr_adr     (wr_adr),
      .wr_alive   (wr_alive),
      .rd_adr_a   (adr_brique),
      .rd_alive_a (rd_alive_a),
      .rd_adr_b   (vga_adr),
      .rd_alive_b (rd_alive_b)
   );

   // The bitmap is half-written during INIT, so both ports are blanked.
   assign brique_morte = in_init || !rd_alive_a;
   assign vga_alive    = !in_init && rd_alive_b;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_INIT;
         init_ptr     <= '0;
         tmo_cnt      <= '0;
         perdu_q      <= 1'b0;
         kill_q       <= 1'b0;
         en           <= 1'b0;
         pos_raquette <= '0;
         ball_x       <= '0;
         ball_y       <= '0;
         nb_restantes <= '0;
         all_cleared  <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         en          <= 1'b0;
         kill_q      <= kill_ok;
         all_cleared <= !in_init && (nb_restantes == '0);

         // Port A read of the killed address returns the pre-kill status one
         // cycle later, which tells us whether this kill actually removed a brick.
         if (kill_q && rd_alive_a) begin
            nb_restantes <= nb_restantes - CNT_ONE;
         end

         if (perdu && !in_init) begin
            perdu_q <= 1'b1;
         end

         case (state)
            ST_INIT: begin
               init_ptr <= init_ptr + ADR_ONE;
               if (init_ptr == LAST_ADR) begin
                  init_ptr     <= '0;
                  nb_restantes <= NB_CNT;
                  timeout_err  <= 1'b0;
                  perdu_q      <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (frame_start) begin
                  if (perdu_q) begin
                     state <= ST_INIT;
                  end else begin
                     state        <= ST_CALC;
                     en           <= 1'b1;
                     pos_raquette <= raquette_in;
                     tmo_cnt      <= TMO_LOAD;
                  end
               end
            end
            ST_CALC: begin
               if (fincalcul) begin
                  ball_x <= x_position;
                  ball_y <= y_position;
                  state  <= ST_IDLE;
               end else if (tmo_cnt == '0) begin
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - TMO_ONE;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule
